// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and data access.
// Round-robin arbitration with request hold, in-order owner FIFO for response routing.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   instr_req_i,
    input  logic [ADDR_WIDTH-1:0]                  instr_addr_i,
    output logic                                   instr_gnt_o,
    output logic                                   instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  instr_rdata_o,
    input  logic                                   data_req_i,
    input  logic [ADDR_WIDTH-1:0]                  data_addr_i,
    input  logic                                   data_we_i,
    input  logic [DATA_WIDTH/8-1:0]                data_be_i,
    input  logic [DATA_WIDTH-1:0]                  data_wdata_i,
    output logic                                   data_gnt_o,
    output logic                                   data_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  data_rdata_o,
    output logic                                   data_err_o,
    output logic                                   mem_req_o,
    output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
    output logic                                   mem_we_o,
    output logic [DATA_WIDTH/8-1:0]                mem_be_o,
    output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
    input  logic                                   mem_gnt_i,
    input  logic                                   mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,
    input  logic                                   mem_err_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);
    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [0:0] ARB  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam logic OWNER_INSTR = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    logic [0:0]                 state_q, state_d;
    logic                       hold_owner_q, hold_owner_d;
    logic                       last_owner_q, last_owner_d;
    logic [MAX_OUTSTANDING-1:0] owner_fifo_q, owner_fifo_d;
    logic [PTR_WIDTH-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]       count_q, count_d;

    logic req;
    logic owner;
    logic push;
    logic pop;
    logic head_owner;
    logic can_issue;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Eligibility looks at the registered count so a same-cycle pop cannot open a slot.
    assign can_issue = (count_q < CNT_WIDTH'(MAX_OUTSTANDING));

    always_comb begin
        req   = 1'b0;
        owner = hold_owner_q;
        if (!rst_i) begin
            if (state_q == HOLD) begin
                req   = 1'b1;
                owner = hold_owner_q;
            end else if (can_issue && (instr_req_i || data_req_i)) begin
                req = 1'b1;
                if (instr_req_i && data_req_i) begin
                    owner = ~last_owner_q;
                end else begin
                    owner = data_req_i ? OWNER_DATA : OWNER_INSTR;
                end
            end
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (req) begin
            if (owner == OWNER_DATA) begin
                mem_addr_o  = data_addr_i;
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_addr_o  = instr_addr_i;
                mem_be_o    = {BE_WIDTH{1'b1}};
            end
        end
    end

    assign mem_req_o   = req;
    assign push        = req & mem_gnt_i;
    assign instr_gnt_o = push & (owner == OWNER_INSTR);
    assign data_gnt_o  = push & (owner == OWNER_DATA);

    assign head_owner     = owner_fifo_q[rd_ptr_q];
    assign pop            = !rst_i && mem_rvalid_i && (count_q != '0);
    assign instr_rvalid_o = pop & (head_owner == OWNER_INSTR);
    assign data_rvalid_o  = pop & (head_owner == OWNER_DATA);
    assign data_err_o     = data_rvalid_o & mem_err_i;
    assign instr_rdata_o  = pop ? mem_rdata_i : '0;
    assign data_rdata_o   = pop ? mem_rdata_i : '0;
    assign outstanding_o  = count_q;

    always_comb begin
        state_d      = ((req && !mem_gnt_i) ? HOLD : ARB);
        hold_owner_d = (req && !mem_gnt_i) ? owner : hold_owner_q;
        last_owner_d = last_owner_q;
        owner_fifo_d = owner_fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (push) begin
            owner_fifo_d[wr_ptr_q] = owner;
            wr_ptr_d               = ptr_inc(wr_ptr_q);
            last_owner_d           = owner;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB;
            hold_owner_q <= OWNER_INSTR;
            last_owner_q <= OWNER_DATA;
            owner_fifo_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            hold_owner_q <= hold_owner_d;
            last_owner_q <= last_owner_d;
            owner_fifo_q <= owner_fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // A response with nothing in flight has no owner; it is dropped and flagged.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(mem_rvalid_i && (count_q == '0)))
                else $warning("mem_rvalid_i with empty owner FIFO dropped");
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: queue-based reference model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           instr_req_i;
    logic [AW-1:0]  instr_addr_i;
    logic           instr_gnt_o;
    logic           instr_rvalid_o;
    logic [DW-1:0]  instr_rdata_o;
    logic           data_req_i;
    logic [AW-1:0]  data_addr_i;
    logic           data_we_i;
    logic [3:0]     data_be_i;
    logic [DW-1:0]  data_wdata_i;
    logic           data_gnt_o;
    logic           data_rvalid_o;
    logic [DW-1:0]  data_rdata_o;
    logic           data_err_o;
    logic           mem_req_o;
    logic [AW-1:0]  mem_addr_o;
    logic           mem_we_o;
    logic [3:0]     mem_be_o;
    logic [DW-1:0]  mem_wdata_o;
    logic           mem_gnt_i;
    logic           mem_rvalid_i;
    logic [DW-1:0]  mem_rdata_i;
    logic           mem_err_i;
    logic [1:0]     outstanding_o;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .outstanding_o(outstanding_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owners in flight (1 = data), last granted owner, and the
    // owner that was presented but not yet granted (-1 when none).
    logic model_q[$];
    logic last_data = 1'b1;
    int   held      = -1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void decide(output logic r, output logic o);
        r = 1'b0;
        o = 1'b0;
        if (rst_i) return;
        if (held >= 0) begin
            r = 1'b1;
            o = (held == 1);
        end else if (model_q.size() < MO && (instr_req_i || data_req_i)) begin
            r = 1'b1;
            o = (instr_req_i && data_req_i) ? !last_data : data_req_i;
        end
    endfunction

    always @(negedge clk_i) begin
        logic r, o, p, h;
        decide(r, o);
        p = !rst_i && mem_rvalid_i && (model_q.size() > 0);
        h = p ? model_q[0] : 1'b0;
        chk("mem_req",   mem_req_o,   r);
        chk("mem_addr",  mem_addr_o,  r ? (o ? data_addr_i : instr_addr_i) : 32'h0);
        chk("mem_we",    mem_we_o,    r & o & data_we_i);
        chk("mem_be",    mem_be_o,    r ? (o ? data_be_i : 4'hF) : 4'h0);
        chk("mem_wdata", mem_wdata_o, (r & o) ? data_wdata_i : 32'h0);
        chk("instr_gnt", instr_gnt_o, r & mem_gnt_i & !o);
        chk("data_gnt",  data_gnt_o,  r & mem_gnt_i & o);
        chk("instr_rvalid", instr_rvalid_o, p & !h);
        chk("data_rvalid",  data_rvalid_o,  p & h);
        chk("data_err",     data_err_o,     p & h & mem_err_i);
        if (p) begin
            chk("instr_rdata", instr_rdata_o, mem_rdata_i);
            chk("data_rdata",  data_rdata_o,  mem_rdata_i);
        end
        chk("outstanding", outstanding_o, model_q.size());
    end

    always @(posedge clk_i) begin
        logic r, o, p;
        if (rst_i) begin
            model_q.delete();
            last_data = 1'b1;
            held      = -1;
        end else begin
            decide(r, o);
            p = mem_rvalid_i && (model_q.size() > 0);
            if (p) void'(model_q.pop_front());
            if (r && mem_gnt_i) begin
                model_q.push_back(o);
                last_data = o;
                held      = -1;
            end else if (r) begin
                held = o ? 1 : 0;
            end
        end
    end

    task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [31:0] da, input logic we,
                        input logic [3:0] be, input logic [31:0] wd, input logic g,
                        input logic rv, input logic [31:0] rd, input logic er);
        @(posedge clk_i);
        #1;
        rst_i = rst; instr_req_i = ir; instr_addr_i = ia;
        data_req_i = dr; data_addr_i = da; data_we_i = we; data_be_i = be; data_wdata_i = wd;
        mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd; mem_err_i = er;
        @(negedge clk_i);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_i = 1'b1; instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_addr_i = 0;
        data_we_i = 0; data_be_i = 0; data_wdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
        mem_rdata_i = 0; mem_err_i = 0;

        step(1, 1, 32'h20, 1, 32'h24, 0, 4'hF, 0, 1, 1, 32'h5, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // instruction-only fetch
        step(0, 1, 32'h20, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("t1_instr_gnt", instr_gnt_o, 1);
        chk("t1_mem_addr", mem_addr_o, 32'h20);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13, 0);
        chk("t1_instr_rvalid", instr_rvalid_o, 1);
        chk("t1_instr_rdata", instr_rdata_o, 32'h13);
        chk("t1_data_rvalid", data_rvalid_o, 0);
        chk("t1_outstanding1", outstanding_o, 1);
        idle();
        chk("t1_outstanding0", outstanding_o, 0);

        // simultaneous requests alternate
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h40, 1, 32'h200, 0, 4'hF, 0, 1, 0, 0, 0);
        chk("t2_g0_instr", instr_gnt_o, 1);
        chk("t2_g0_data", data_gnt_o, 0);
        step(0, 1, 32'h44, 1, 32'h200, 0, 4'hF, 0, 1, 1, 32'hA1, 0);
        chk("t2_g1_data", data_gnt_o, 1);
        chk("t2_r0_instr", instr_rvalid_o, 1);
        step(0, 1, 32'h44, 1, 32'h204, 0, 4'hF, 0, 1, 1, 32'hA2, 0);
        chk("t2_g2_instr", instr_gnt_o, 1);
        chk("t2_r1_data", data_rvalid_o, 1);
        chk("t2_r1_rdata", data_rdata_o, 32'hA2);
        step(0, 1, 32'h48, 1, 32'h204, 0, 4'hF, 0, 1, 1, 32'hA3, 0);
        chk("t2_g3_data", data_gnt_o, 1);
        chk("t2_r2_instr", instr_rvalid_o, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA4, 0);
        chk("t2_r3_data", data_rvalid_o, 1);
        idle();

        // hold stability: data write waits 3 cycles while instr_req rises
        step(0, 0, 0, 1, 32'h100, 1, 4'h3, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("t3_addr0", mem_addr_o, 32'h100);
        step(0, 1, 32'h80, 1, 32'h100, 1, 4'h3, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("t3_we1", mem_we_o, 1);
        chk("t3_addr1", mem_addr_o, 32'h100);
        step(0, 1, 32'h80, 1, 32'h100, 1, 4'h3, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("t3_wdata2", mem_wdata_o, 32'hDEADBEEF);
        chk("t3_be2", mem_be_o, 4'h3);
        step(0, 1, 32'h80, 1, 32'h100, 1, 4'h3, 32'hDEADBEEF, 1, 0, 0, 0);
        chk("t3_data_gnt", data_gnt_o, 1);
        chk("t3_no_instr_gnt", instr_gnt_o, 0);
        step(0, 1, 32'h80, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("t3_instr_gnt", instr_gnt_o, 1);
        chk("t3_instr_addr", mem_addr_o, 32'h80);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
        chk("t3_wack", data_rvalid_o, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55, 0);
        chk("t3_fetch", instr_rdata_o, 32'h55);
        idle();

        // full FIFO blocks new requests until a response arrives
        step(0, 1, 32'hC0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 32'hC4, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("t4_second_gnt", instr_gnt_o, 1);
        step(0, 1, 32'hC8, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("t4_full_req", mem_req_o, 0);
        chk("t4_full_cnt", outstanding_o, 2);
        step(0, 1, 32'hC8, 0, 0, 0, 0, 0, 1, 1, 32'h1, 0);
        chk("t4_pop_no_req", mem_req_o, 0);
        chk("t4_pop_rvalid", instr_rvalid_o, 1);
        step(0, 1, 32'hC8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_req_again", mem_req_o, 1);
        step(0, 1, 32'hC8, 0, 0, 0, 0, 0, 0, 1, 32'h2, 0);
        step(0, 1, 32'hC8, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("t4_hold_gnt", instr_gnt_o, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3, 0);
        idle();
        chk("t4_drained", outstanding_o, 0);

        // error routing
        step(0, 0, 0, 1, 32'h300, 0, 4'hF, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD, 1);
        chk("t5_data_err", data_err_o, 1);
        step(0, 1, 32'hE0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77, 1);
        chk("t5_instr_rvalid", instr_rvalid_o, 1);
        chk("t5_instr_no_err", data_err_o, 0);

        // reset with two outstanding, then stray responses
        step(0, 1, 32'hF0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 32'h400, 0, 4'hF, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h9, 0);
        chk("t6_rst_cnt", outstanding_o, 2);
        chk("t6_rst_no_rv", instr_rvalid_o | data_rvalid_o, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h9, 0);
        chk("t6_stray1", instr_rvalid_o | data_rvalid_o, 0);
        chk("t6_cnt0", outstanding_o, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h9, 0);
        chk("t6_stray2", instr_rvalid_o | data_rvalid_o, 0);
        step(0, 1, 32'h10, 1, 32'h500, 0, 4'hF, 0, 1, 0, 0, 0);
        chk("t6_instr_first", instr_gnt_o, 1);
        chk("t6_data_wait", data_gnt_o, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11, 0);
        chk("t6_fetch", instr_rvalid_o, 1);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
